// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package cpu_pkg;

  // ADDI x0, x0, 0: presented on decode whenever IF/ID holds a bubble.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Contents of the IF/ID pipeline register (and of the skid entry).
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // The empty IF/ID value; the PC field is supplied by the caller because it is held.
  function automatic if_id_t make_bubble(input logic [31:0] pc);
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = pc;
    b.instr = NOP_INSTR;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch response that arrives while decode is stalled.
module fetch_skid_buffer
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout,
  output logic   full
);

  if_id_t entry;
  logic   occupied;

  // Capture on push, release on pop; clear (redirect) dominates both.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupied <= 1'b0;
      entry    <= make_bubble(32'h0000_0000);
    end else if (clear) begin
      occupied <= 1'b0;
      entry    <= make_bubble(32'h0000_0000);
    end else if (push) begin
      occupied <= 1'b1;
      entry    <= din;
    end else if (pop) begin
      occupied <= 1'b0;
      entry    <= entry;
    end else begin
      occupied <= occupied;
      entry    <= entry;
    end
  end

  assign dout = entry;
  assign full = occupied;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        decode_valid,
  output logic [31:0] decode_pc,
  output logic [31:0] decode_instr
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic [31:0]  req_addr;   // address of the request currently in flight
  if_id_t       if_id;
  if_id_t       if_id_next;
  if_id_t       skid_dout;
  logic         skid_full;
  logic         skid_push;
  logic         skid_pop;
  logic         req_fire;
  logic         accept;     // response that belongs to a live request

  assign req_fire = imem_req & imem_gnt;
  assign accept   = (state == WAIT) & imem_rvalid & ~redirect_valid;

  // Next state and request generation; a response in WAIT may reissue in the same cycle.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req = ~skid_full;
        if (redirect_valid) begin
          state_next = (imem_req & imem_gnt) ? DRAIN : REQ;
        end else if (imem_req & imem_gnt) begin
          state_next = WAIT;
        end else begin
          state_next = REQ;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response landing with the redirect closes the outstanding request itself.
          state_next = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          imem_req   = ~stall & ~skid_full;
          state_next = (imem_req & imem_gnt) ? WAIT : REQ;
        end else begin
          state_next = WAIT;
        end
      end
      DRAIN: begin
        state_next = imem_rvalid ? REQ : DRAIN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC advances on each grant; a redirect overrides with a word-aligned target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end else begin
        pc <= pc;
      end
      if (req_fire) begin
        req_addr <= pc;
      end else begin
        req_addr <= req_addr;
      end
    end
  end

  assign imem_addr = pc;

  // Skid control: park a stalled response, release it when stall drops.
  assign skid_push = accept & stall;
  assign skid_pop  = ~redirect_valid & ~accept & ~stall & skid_full;

  // IF/ID next value: redirect bubble, fresh response, skid entry, hold, or bubble.
  always_comb begin
    if_id_next = if_id;
    if (redirect_valid) begin
      if_id_next = make_bubble(if_id.pc);
    end else if (accept && !stall) begin
      if_id_next.valid = 1'b1;
      if_id_next.pc    = req_addr;
      if_id_next.instr = imem_rdata;
    end else if (skid_pop) begin
      if_id_next = skid_dout;
    end else if (stall) begin
      if_id_next = if_id;
    end else begin
      if_id_next = make_bubble(if_id.pc);
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id <= make_bubble(32'h0000_0000);
    end else begin
      if_id <= if_id_next;
    end
  end

  fetch_skid_buffer u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .clear (redirect_valid),
    .din   ({1'b1, req_addr, imem_rdata}),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  assign decode_valid = if_id.valid;
  assign decode_pc    = if_id.pc;
  assign decode_instr = if_id.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the bench plays the instruction memory cycle by cycle.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        decode_valid;
  logic [31:0] decode_pc;
  logic [31:0] decode_instr;

  int n_vec;
  int n_err;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .decode_valid   (decode_valid),
    .decode_pc      (decode_pc),
    .decode_instr   (decode_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply one cycle's inputs and let combinational outputs settle.
  task automatic drv(input logic s, input logic rv, input logic [31:0] rpc,
                     input logic g, input logic v, input logic [31:0] d);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_gnt       = g;
    imem_rvalid    = v;
    imem_rdata     = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},     32'd0);
    check({tag, "_addr"},  imem_addr,             32'h0000_0000);
    check({tag, "_valid"}, {31'd0, decode_valid}, 32'd0);
    check({tag, "_pc"},    decode_pc,             32'h0000_0000);
    check({tag, "_instr"}, decode_instr,          NOP);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step();
    step();
    check_reset_outputs("rst");

    // Release reset: IDLE for one cycle, first request in the second.
    rst = 1'b0;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check("req0_req", {31'd0, imem_req}, 32'd1);
    check("req0_addr", imem_addr, 32'h0000_0000);
    step();
    // Zero-wait memory: response for 0x0 and back-to-back request for 0x4.
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0000);
    check("b2b4_req", {31'd0, imem_req}, 32'd1);
    check("b2b4_addr", imem_addr, 32'h0000_0004);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hA000_0004);
    check("d0_valid", {31'd0, decode_valid}, 32'd1);
    check("d0_pc", decode_pc, 32'h0000_0000);
    check("d0_instr", decode_instr, 32'hA000_0000);
    check("b2b8_addr", imem_addr, 32'h0000_0008);
    step();
    // Response for 0x8 lands while stalled.
    drv(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0008);
    check("d4_valid", {31'd0, decode_valid}, 32'd1);
    check("d4_pc", decode_pc, 32'h0000_0004);
    check("d4_instr", decode_instr, 32'hA000_0004);
    check("stall_noreq", {31'd0, imem_req}, 32'd0);
    step();
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      check("stall_hold_pc", decode_pc, 32'h0000_0004);
      check("stall_hold_valid", {31'd0, decode_valid}, 32'd1);
      check("skid_full_noreq", {31'd0, imem_req}, 32'd0);
      step();
    end
    // Stall drops: skid entry moves to IF/ID, request still held off this cycle.
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check("unstall_noreq", {31'd0, imem_req}, 32'd0);
    check("unstall_hold_pc", decode_pc, 32'h0000_0004);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check("skid_pc", decode_pc, 32'h0000_0008);
    check("skid_instr", decode_instr, 32'hA000_0008);
    check("skid_valid", {31'd0, decode_valid}, 32'd1);
    check("resume_req", {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, 32'h0000_000C);
    step();
    // 0xC in flight; redirect to 0x100 while waiting.
    drv(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
    check("bubble_valid", {31'd0, decode_valid}, 32'd0);
    check("bubble_instr", decode_instr, NOP);
    check("bubble_pc_hold", decode_pc, 32'h0000_0008);
    check("wait_redir_noreq", {31'd0, imem_req}, 32'd0);
    step();
    // Stale response for 0xC is drained.
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    check("redir_valid", {31'd0, decode_valid}, 32'd0);
    check("drain_noreq", {31'd0, imem_req}, 32'd0);
    step();
    // Grant withheld for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      check("nogrant_req", {31'd0, imem_req}, 32'd1);
      check("nogrant_addr", imem_addr, 32'h0000_0100);
      check("drain_instr", decode_instr, NOP);
      check("drain_valid", {31'd0, decode_valid}, 32'd0);
      step();
    end
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check("grant100_addr", imem_addr, 32'h0000_0100);
    step();
    // Response for 0x100 parked in the skid buffer under stall.
    drv(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_0100);
    check("park_noreq", {31'd0, imem_req}, 32'd0);
    step();
    // Redirect together with stall while the skid buffer is full.
    drv(1'b1, 1'b1, 32'h0000_0203, 1'b0, 1'b0, 32'd0);
    check("full_noreq", {31'd0, imem_req}, 32'd0);
    check("full_valid", {31'd0, decode_valid}, 32'd0);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check("rs_valid", {31'd0, decode_valid}, 32'd0);
    check("rs_req", {31'd0, imem_req}, 32'd1);
    check("rs_addr", imem_addr, 32'h0000_0200);
    step();
    // Cleared skid entry must not surface.
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("rs_noskid_valid", {31'd0, decode_valid}, 32'd0);
    check("rs_noskid_instr", decode_instr, NOP);
    // Reset while waiting for 0x200.
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    check("late_idle_req", {31'd0, imem_req}, 32'd0);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBAD0_BAD0);
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0000_0000);
    check("late_valid", {31'd0, decode_valid}, 32'd0);
    step();
    // Stale rvalid ignored; redirect in REQ without grant moves the address.
    drv(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
    check("stale_valid", {31'd0, decode_valid}, 32'd0);
    check("stale_instr", decode_instr, NOP);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check("top_req", {31'd0, imem_req}, 32'd1);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    // PC wraps silently to 0 on the back-to-back request.
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hA000_FFFC);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    step();
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check("wrap_dpc", decode_pc, 32'hFFFF_FFFC);
    check("wrap_dinstr", decode_instr, 32'hA000_FFFC);
    check("wrap_dvalid", {31'd0, decode_valid}, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
